// File: rtl/branch_pkg.sv
// Shared definitions for the branch prediction unit: jump-type encodings,
// condition-code bit positions and the 2-bit saturating counter step.
package branch_pkg;

  typedef enum logic [1:0] {
    JT_JZ  = 2'd0,
    JT_JN  = 2'd1,
    JT_JC  = 2'd2,
    JT_JMP = 2'd3
  } jtype_e;

  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;

  // Weakly not-taken: one taken outcome flips the prediction.
  localparam logic [1:0] CTR_RESET = 2'b01;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_pred_unit_if.sv
// Fetch lookup, execute resolution and redirect/statistics signals of the
// branch prediction unit.
interface branch_pred_unit_if #(
  parameter int PC_W  = 32,
  parameter int TGT_W = 16
);
  logic             f_valid;
  logic             f_is_branch;
  logic [PC_W-1:0]  f_pc;
  logic             f_pred_taken;

  logic             ex_valid;
  logic             ex_branch;
  logic [1:0]       ex_jtype;
  logic [2:0]       ex_ccr;
  logic [PC_W-1:0]  ex_pc;
  logic [TGT_W-1:0] ex_rdst;
  logic             ex_pred_taken;
  logic             ex_taken;

  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [15:0]      branch_cnt;
  logic [15:0]      mispred_cnt;

  modport master (
    output f_valid, f_is_branch, f_pc,
    output ex_valid, ex_branch, ex_jtype, ex_ccr, ex_pc, ex_rdst, ex_pred_taken,
    input  f_pred_taken, ex_taken, redirect, redirect_pc, branch_cnt, mispred_cnt
  );

  modport slave (
    input  f_valid, f_is_branch, f_pc,
    input  ex_valid, ex_branch, ex_jtype, ex_ccr, ex_pc, ex_rdst, ex_pred_taken,
    output f_pred_taken, ex_taken, redirect, redirect_pc, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_hist_table.sv
// Branch history table: 2**IDX_W two-bit saturating counters with one
// combinational read port and one synchronous write (train) port.
module branch_hist_table
  import branch_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] ctr_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_reg[i] <= CTR_RESET;
    end else if (wr_en) begin
      ctr_reg[wr_idx] <= ctr_step(ctr_reg[wr_idx], wr_taken);
    end
  end

  // Read sees the pre-edge value; a same-cycle train is visible next cycle.
  assign rd_ctr = ctr_reg[rd_idx];

endmodule

// File: rtl/branch_pred_unit.sv
// Branch prediction unit: BHT lookup at fetch, outcome resolution and
// training at execute, registered mispredict redirect and statistics.
module branch_pred_unit
  import branch_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int TGT_W = 16,
  parameter int IDX_W = 4
) (
  input logic               clk,
  input logic               rst,
  branch_pred_unit_if.slave bus
);
  logic            resolve;
  logic            flag_sel;
  logic            taken;
  logic            mispred;
  logic [1:0]      rd_ctr;
  logic            redirect_reg;
  logic [PC_W-1:0] redirect_pc_reg;
  logic [PC_W-1:0] redirect_pc_next;
  logic [15:0]     branch_cnt_reg;
  logic [15:0]     mispred_cnt_reg;

  always_comb begin
    flag_sel = 1'b0;
    case (jtype_e'(bus.ex_jtype))
      JT_JZ:   flag_sel = bus.ex_ccr[CCR_Z];
      JT_JN:   flag_sel = bus.ex_ccr[CCR_N];
      JT_JC:   flag_sel = bus.ex_ccr[CCR_C];
      JT_JMP:  flag_sel = 1'b1;
      default: flag_sel = 1'b0;
    endcase
  end

  // The instruction in execute during a redirect cycle is wrong-path.
  assign resolve = bus.ex_valid & (bus.ex_branch === 1'b1) & ~redirect_reg;
  assign taken   = resolve & flag_sel;
  assign mispred = resolve & (taken != bus.ex_pred_taken);

  assign redirect_pc_next = taken ? PC_W'(bus.ex_rdst) : (bus.ex_pc + PC_W'(1));

  branch_hist_table #(
    .IDX_W (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bus.f_pc[IDX_W-1:0]),
    .rd_ctr   (rd_ctr),
    .wr_en    (resolve),
    .wr_idx   (bus.ex_pc[IDX_W-1:0]),
    .wr_taken (taken)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
      branch_cnt_reg  <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      redirect_reg <= mispred;
      if (mispred) redirect_pc_reg <= redirect_pc_next;
      if (resolve && branch_cnt_reg != 16'hFFFF) branch_cnt_reg <= branch_cnt_reg + 16'd1;
      if (mispred && mispred_cnt_reg != 16'hFFFF) mispred_cnt_reg <= mispred_cnt_reg + 16'd1;
    end
  end

  assign bus.f_pred_taken = bus.f_valid & bus.f_is_branch & rd_ctr[1];
  assign bus.ex_taken     = taken;
  assign bus.redirect     = redirect_reg;
  assign bus.redirect_pc  = redirect_pc_reg;
  assign bus.branch_cnt   = branch_cnt_reg;
  assign bus.mispred_cnt  = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Bench for branch_pred_unit: directed vector table, hand sequences for
// reset/saturation corners, and random traffic against a behavioural model.
`timescale 1ns/100ps
module tb_branch_pred_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_pred_unit_if #(.PC_W(32), .TGT_W(16)) bus ();

  branch_pred_unit #(.PC_W(32), .TGT_W(16), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: counters as plain integers 0..3, stats as ints.
  int          bht [16];
  bit          m_redir = 1'b0;
  logic [31:0] m_rpc = '0;
  int          m_b = 0;
  int          m_m = 0;
  bit          m_init = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit exv, input bit exb, input bit [1:0] jt, input bit [2:0] ccr,
                       input bit [31:0] pc, input bit [15:0] rdst, input bit pred,
                       input bit fv, input bit fb, input bit [31:0] fpc);
    bus.ex_valid = exv; bus.ex_branch = exb; bus.ex_jtype = jt; bus.ex_ccr = ccr;
    bus.ex_pc = pc; bus.ex_rdst = rdst; bus.ex_pred_taken = pred;
    bus.f_valid = fv; bus.f_is_branch = fb; bus.f_pc = fpc;
  endtask

  // One clock: check combinational outputs, advance model over the edge, check registers.
  task automatic step();
    bit res, tk, pr, mis;
    int idx;
    #2;
    res = bus.ex_valid && bus.ex_branch && !m_redir;
    tk  = res && (bus.ex_jtype == 2'd3 || bus.ex_ccr[bus.ex_jtype]);
    pr  = bus.f_valid && bus.f_is_branch && (bht[bus.f_pc[3:0]] >= 2);
    mis = res && (tk != bus.ex_pred_taken);
    idx = int'(bus.ex_pc[3:0]);
    if (m_init) begin
      chk("f_pred_taken", bus.f_pred_taken, pr);
      chk("ex_taken", bus.ex_taken, tk);
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 16; i++) bht[i] = 1;
      m_redir = 0; m_rpc = '0; m_b = 0; m_m = 0; m_init = 1;
    end else begin
      if (res) begin
        bht[idx] = tk ? ((bht[idx] < 3) ? bht[idx] + 1 : 3) : ((bht[idx] > 0) ? bht[idx] - 1 : 0);
        if (m_b < 65535) m_b++;
        if (mis) begin
          if (m_m < 65535) m_m++;
          m_rpc = tk ? {16'h0, bus.ex_rdst} : bus.ex_pc + 32'd1;
        end
      end
      m_redir = mis;
    end
    #1;
    if (m_init) begin
      chk("redirect", bus.redirect, m_redir);
      chk("redirect_pc", bus.redirect_pc, m_rpc);
      chk("branch_cnt", bus.branch_cnt, m_b);
      chk("mispred_cnt", bus.mispred_cnt, m_m);
    end
  endtask

  typedef struct {
    bit exv, exb; bit [1:0] jt; bit [2:0] ccr; bit [31:0] pc; bit [15:0] rdst; bit pred;
    bit fv, fb; bit [31:0] fpc;
    bit e_fpred, e_taken, e_redir; bit [31:0] e_rpc; int e_b, e_m;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // exv exb jt ccr pc rdst pred fv fb fpc | fpred taken redir rpc b m
    vecs[0] = '{0,0,2'd0,3'b000,32'h0,       16'h0,   0,1,1,32'd5,  0,0,0,32'h0,  0,0};
    vecs[1] = '{1,1,2'd0,3'b001,32'd5,       16'h40,  0,1,1,32'd5,  0,1,1,32'h40, 1,1};
    vecs[2] = '{1,1,2'd3,3'b000,32'd5,       16'h77,  0,1,1,32'd5,  1,0,0,32'h40, 1,1};
    vecs[3] = '{1,1,2'd2,3'b011,32'hFFFFFFFF,16'h1234,0,1,1,32'd15, 0,0,0,32'h40, 2,1};
    vecs[4] = '{1,1,2'd1,3'b010,32'hFFFFFFFF,16'h55,  1,1,1,32'd15, 0,1,0,32'h40, 3,1};
    vecs[5] = '{1,1,2'd1,3'b000,32'hFFFFFFFF,16'h99,  1,1,1,32'd5,  1,0,1,32'h0,  4,2};
    vecs[6] = '{0,0,2'd0,3'b000,32'h0,       16'h0,   0,0,1,32'd5,  0,0,0,32'h0,  4,2};

    drive(0,0,0,0,0,0,0,0,0,0);
    rst = 1'b0;
    step(); step();
    rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].exv, vecs[v].exb, vecs[v].jt, vecs[v].ccr, vecs[v].pc, vecs[v].rdst,
            vecs[v].pred, vecs[v].fv, vecs[v].fb, vecs[v].fpc);
      #2;
      chk("vec_f_pred", bus.f_pred_taken, vecs[v].e_fpred);
      chk("vec_ex_taken", bus.ex_taken, vecs[v].e_taken);
      step();
      chk("vec_redirect", bus.redirect, vecs[v].e_redir);
      chk("vec_redirect_pc", bus.redirect_pc, vecs[v].e_rpc);
      chk("vec_branch_cnt", bus.branch_cnt, vecs[v].e_b);
      chk("vec_mispred_cnt", bus.mispred_cnt, vecs[v].e_m);
      $display("vec %0d: redirect=%0b redirect_pc=%0h branch_cnt=%0d mispred_cnt=%0d",
               v, bus.redirect, bus.redirect_pc, bus.branch_cnt, bus.mispred_cnt);
    end

    // Counter saturation: four taken JMPs, then one not-taken still predicts taken.
    for (int k = 0; k < 4; k++) begin
      drive(1,1,2'd3,3'b000,32'd3,16'h10,1,0,0,0);
      step();
    end
    drive(1,1,2'd0,3'b000,32'd3,16'h10,0,1,1,32'd3);
    step();
    #1;
    chk("sat3_lookup", bus.f_pred_taken, 1);
    $display("sat seq: f_pred_taken(pc=3)=%0b after 4 JMP + 1 not-taken", bus.f_pred_taken);

    // Mispredict followed by reset: pending redirect dropped, everything cleared.
    drive(1,1,2'd0,3'b001,32'd7,16'h20,0,0,0,0);
    step();
    rst = 1'b0;
    drive(1,1,2'd3,3'b000,32'd7,16'h20,0,0,0,0);
    step();
    rst = 1'b1;
    chk("rst_redirect", bus.redirect, 0);
    chk("rst_branch_cnt", bus.branch_cnt, 0);
    drive(0,0,0,0,0,0,0,1,1,0);
    for (int i = 0; i < 16; i++) begin
      bus.f_pc = 32'(i);
      #0.2;
      chk("rst_f_pred", bus.f_pred_taken, 0);
    end
    $display("reset seq: redirect=%0b branch_cnt=%0d mispred_cnt=%0d",
             bus.redirect, bus.branch_cnt, bus.mispred_cnt);
    step();

    // Random traffic with occasional reset; small PC space forces index collisions.
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 31)),
            16'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 32'($urandom));
      step();
    end
    rst = 1'b1;
    $display("random: branch_cnt=%0d mispred_cnt=%0d", bus.branch_cnt, bus.mispred_cnt);

    // Statistics saturation: correctly predicted JMPs, one extra cycle clears any redirect.
    drive(0,0,0,0,0,0,0,0,0,0);
    step();
    for (int c = 0; c < 70000; c++) begin
      drive(1,1,2'd3,3'b000,32'd3,16'h10,1,0,0,0);
      step();
    end
    chk("branch_cnt_sat", bus.branch_cnt, 16'hFFFF);
    $display("sat cnt: branch_cnt=%0h", bus.branch_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_pred_unit.md
BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter width.
REQ-002 SHALL have parameter TGT_W, default 16, jump-target register width (TGT_W <= PC_W).
REQ-003 SHALL have parameter IDX_W, default 4, BHT index width (depth 2**IDX_W).
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports f_valid in 1, f_is_branch in 1, f_pc in PC_W: fetch-stage lookup request.
REQ-007 SHALL have port f_pred_taken  out  1  prediction for the fetched instruction.
REQ-008 SHALL have ports ex_valid in 1, ex_branch in 1, ex_jtype in 2, ex_ccr in 3, ex_pc in PC_W, ex_rdst in TGT_W, ex_pred_taken in 1: execute-stage resolution inputs.
REQ-009 SHALL have port ex_taken  out  1  combinational actual branch outcome.
REQ-010 SHALL have ports redirect out 1, redirect_pc out PC_W: registered mispredict flush and corrected fetch address.
REQ-011 SHALL have ports branch_cnt out 16, mispred_cnt out 16: saturating statistics.

Function
REQ-012 SHALL decode ex_jtype: 0=JZ (ccr[0]), 1=JN (ccr[1]), 2=JC (ccr[2]), 3=JMP (unconditional).
REQ-013 SHALL drive ex_taken = resolve & (JMP | selected flag = 1); resolve = ex_valid & ex_branch & ~redirect; X on ex_branch treated as 0.
REQ-014 SHALL hold a BHT of 2**IDX_W 2-bit saturating counters indexed by pc[IDX_W-1:0].
REQ-015 SHALL drive f_pred_taken = f_valid & f_is_branch & counter[f_pc idx][1], combinational, no bypass: a same-cycle update to that entry is not visible until next cycle.
REQ-016 SHALL, on each edge with resolve=1, increment (taken) or decrement (not taken) counter[ex_pc idx], saturating at 3 and 0; JMP trains like any branch.
REQ-017 SHALL register redirect=1 one cycle after a resolve cycle where ex_taken != ex_pred_taken; otherwise redirect=0 next cycle.
REQ-018 SHALL register redirect_pc = zero-extended ex_rdst if ex_taken, else ex_pc+1 (modulo 2**PC_W, wraps to 0).
REQ-019 SHALL hold redirect_pc stable when redirect=0 (value don't-care to consumers, but no toggling).
REQ-020 SHALL treat the execute instruction present in any cycle with redirect=1 as wrong-path: no outcome, no BHT update, no counter change.
REQ-021 SHALL increment branch_cnt on each resolve cycle and mispred_cnt on each mispredicting resolve cycle, both saturating at 16'hFFFF.
REQ-022 SHALL allow resolve on back-to-back cycles to the same BHT index; each update builds on the previous edge's value.

Reset
REQ-023 SHALL, when rst=0 at a rising edge, set all BHT counters to 2'b01, redirect=0, redirect_pc=0, branch_cnt=0, mispred_cnt=0.
REQ-024 SHALL ignore all resolve activity during reset cycles; reset asserted mid-mispredict drops the pending redirect.
REQ-025 SHALL produce f_pred_taken=0 for every index in the first cycle after reset.

Structure
REQ-026 SHALL take jtype encodings, CCR bit indices and the BHT counter reset value from shared package branch_pkg.
REQ-027 SHALL place the counter array and its saturating update in sub-module branch_hist_table (params IDX_W; one read port, one write port).

Verification
REQ-028 Reset then f_valid=1, f_is_branch=1, f_pc=5 -> f_pred_taken=0; all counters 0.
REQ-029 Resolve JZ at ex_pc=5, ccr=3'b001, pred=0 -> ex_taken=1; next cycle redirect=1, redirect_pc=zext(ex_rdst=16'h0040)=32'h0040, mispred_cnt=1; lookup of pc=5 then predicts taken.
REQ-030 Resolve JC, ccr=3'b011, pred=0, ex_pc=32'hFFFFFFFF -> ex_taken=0, no redirect, counter at idx 15 drops 01->00, branch_cnt=1.
REQ-031 Mispredict followed by a valid branch in the redirect cycle -> that branch ignored: counts and BHT unchanged, redirect=0 next cycle.
REQ-032 Four consecutive taken JMPs at ex_pc=3 -> counter saturates at 3; 70000 resolves -> branch_cnt holds 16'hFFFF.
REQ-033 Mispredict with rst=0 on following edge -> redirect=0, counters cleared, BHT back to 01.
